// File: rtl/cyber_melody_pkg.sv
// Shared constants, FSM state type and a saturating add used by the period meter.
package cyber_melody_pkg;

  localparam int unsigned CLK_PERIOD_NS  = 20;
  localparam int unsigned TIMEOUT_NS_DEF = 100_000_000;
  localparam logic [31:0] ACC_MAX        = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pm_state_e;

  // 32-bit add that clamps at ACC_MAX instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? ACC_MAX : s[31:0];
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a registered
// one-cycle rising-edge strobe (sync, sync, history, strobe register).
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q, rise_q;

  // Metastability chain, edge history and registered rise strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/period_meter.sv
// Rising-edge-to-rising-edge period meter. Counts CLK_PERIOD ns per clk
// between synchronized rises of wave_in, reports the interval with a
// one-cycle valid strobe, and flags timeout when no rise arrives in time.
// Optional feature: define PERIOD_METER_AVG_EN to report the mean of every
// four consecutive measurements instead of each measurement.
module period_meter
  import cyber_melody_pkg::*;
#(
  parameter int unsigned CLK_PERIOD = CLK_PERIOD_NS,
  parameter int unsigned TIMEOUT_NS = TIMEOUT_NS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wave_in,
  output logic [31:0] period,
  output logic        valid,
  output logic        timeout
);

  localparam logic [31:0] STEP  = 32'(CLK_PERIOD);
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_NS);

  pm_state_e   state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        rise_evt;
  logic        meas_vld;   // a complete interval is in acc_q this cycle
  logic        to_evt;     // measurement abandoned this cycle

  sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (wave_in),
    .rise_o (rise_evt)
  );

  // A rise always wins over an expiring count on the same cycle.
  assign to_evt = (state_q == MEASURE) && !rise_evt && (acc_q >= LIMIT);

  // FSM next state, accumulator and timeout level.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    timeout_d = timeout_q;
    meas_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_evt) begin
          state_d   = MEASURE;
          acc_d     = STEP;
          timeout_d = 1'b0;
        end
      end
      MEASURE: begin
        if (rise_evt) begin
          meas_vld = 1'b1;
          acc_d    = STEP;
        end else if (to_evt) begin
          state_d   = IDLE;
          acc_d     = '0;
          timeout_d = 1'b1;
        end else begin
          acc_d = sat_add(acc_q, STEP);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  logic [33:0] sum_q, sum_d, sum_new;
  logic [1:0]  cnt_q, cnt_d;

  // Collect four measurements, publish their mean on the fourth.
  always_comb begin
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    sum_new  = sum_q + {2'b00, acc_q};
    if (to_evt) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (meas_vld) begin
      if (cnt_q == 2'd3) begin
        period_d = sum_new[33:2];
        valid_d  = 1'b1;
        sum_d    = '0;
        cnt_d    = '0;
      end else begin
        sum_d = sum_new;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Averaging state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end
`else
  // Every completed interval is published directly.
  always_comb begin
    period_d = period_q;
    valid_d  = 1'b0;
    if (meas_vld) begin
      period_d = acc_q;
      valid_d  = 1'b1;
    end
  end
`endif

  // Core state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: rises are driven at known cycles and
// the expected valid strobes are computed from the rise timestamps.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int     CLK  = 20;
  localparam longint TO_A = 100_000_000;
  localparam longint TO_B = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wave_a = 1'b0, wave_b = 1'b0;
  logic [31:0] period_a, period_b;
  logic        valid_a, valid_b, timeout_a, timeout_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int     oc_a[$], oc_b[$];
  longint op_a[$], op_b[$];
  int rises[$];
  int ivals[$];
  bit saw_to_b = 1'b0;

  period_meter #(.CLK_PERIOD(CLK)) dut_a (
    .clk(clk), .rst_n(rst_n), .wave_in(wave_a),
    .period(period_a), .valid(valid_a), .timeout(timeout_a)
  );

  period_meter #(.CLK_PERIOD(CLK), .TIMEOUT_NS(2000)) dut_b (
    .clk(clk), .rst_n(rst_n), .wave_in(wave_b),
    .period(period_b), .valid(valid_b), .timeout(timeout_b)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin oc_a.push_back(cyc); op_a.push_back(longint'(period_a)); end
    if (valid_b) begin oc_b.push_back(cyc); op_b.push_back(longint'(period_b)); end
    if (timeout_b) saw_to_b = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    wave_a = 1'b0; wave_b = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    rises.delete(); ivals.delete();
    oc_a.delete(); op_a.delete(); oc_b.delete(); op_b.delete();
    saw_to_b = 1'b0;
  endtask

  task automatic rise(input bit b);
    @(posedge clk); #1;
    if (b) wave_b = 1'b1; else wave_a = 1'b1;
    rises.push_back(cyc);
    @(posedge clk); #1;
    if (b) wave_b = 1'b0; else wave_a = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n - 2) @(posedge clk);
  endtask

  task automatic run_wave(input bit b);
    rise(b);
    foreach (ivals[k]) begin gap(ivals[k]); rise(b); end
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Expected strobes: a rise measures n cycles since the previous rise unless
  // the count reached the timeout first, in which case the rise only re-arms.
  // A valid appears 4 cycles after the rise is driven.
  task automatic check_model(input string name, input bit b, input longint to_ns);
    int     ec[$];
    longint ep[$];
    bit     armed;
    int     n, kmax, nobs, oc;
    longint d, op;
`ifdef PERIOD_METER_AVG_EN
    int     cnt;
    longint sum;
    cnt = 0; sum = 0;
`endif
    armed = 1'b0;
    kmax = int'((to_ns + CLK - 1) / CLK);
    for (int i = 0; i < rises.size(); i++) begin
      if (!armed) armed = 1'b1;
      else begin
        n = rises[i] - rises[i-1];
        if (n > kmax) begin
`ifdef PERIOD_METER_AVG_EN
          cnt = 0; sum = 0;
`endif
        end else begin
          d = longint'(n) * CLK;
`ifdef PERIOD_METER_AVG_EN
          sum += d; cnt++;
          if (cnt == 4) begin
            ec.push_back(rises[i] + 4); ep.push_back(sum / 4); cnt = 0; sum = 0;
          end
`else
          ec.push_back(rises[i] + 4); ep.push_back(d);
`endif
        end
      end
    end
    nobs = b ? oc_b.size() : oc_a.size();
    checks++;
    if (nobs != ec.size()) begin
      failures++;
      $display("FAIL %s count: got %0d valids expected %0d", name, nobs, ec.size());
    end
    for (int i = 0; i < nobs && i < ec.size(); i++) begin
      oc = b ? oc_b[i] : oc_a[i];
      op = b ? op_b[i] : op_a[i];
      checks++;
      if (oc != ec[i] || op != ep[i]) begin
        failures++;
        $display("FAIL %s #%0d: got cycle %0d period %0d expected cycle %0d period %0d",
                 name, i, oc, op, ec[i], ep[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({period_a, valid_a, timeout_a} !== 34'd0 || {period_b, valid_b, timeout_b} !== 34'd0) begin
      failures++;
      $display("FAIL reset_state: got a=%0d/%0b/%0b b=%0d/%0b/%0b expected all 0",
               period_a, valid_a, timeout_a, period_b, valid_b, timeout_b);
    end
    do_reset();
  endtask

  task automatic test_pulse_gen();
    do_reset();
    repeat (8) ivals.push_back(6);
    run_wave(1'b0);
    check_model("pulse_gen", 1'b0, TO_A);
    checks++;
    if (period_a !== 32'd120) begin
      failures++;
      $display("FAIL pulse_gen_period: got %0d expected 120", period_a);
    end
  endtask

  task automatic test_square_1khz();
    int exp_n;
`ifdef PERIOD_METER_AVG_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    do_reset();
    ivals.push_back(50_000);
    run_wave(1'b0);
    check_model("square_1khz", 1'b0, TO_A);
    checks++;
    if (oc_a.size() != exp_n || (exp_n == 1 && op_a[0] != 64'd1_000_000)) begin
      failures++;
      $display("FAIL square_1khz_value: got %0d valids period %0d expected %0d valids period 1000000",
               oc_a.size(), period_a, exp_n);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (24) ivals.push_back(int'($urandom_range(3, 40)));
    run_wave(1'b0);
    check_model("random_a", 1'b0, TO_A);
    do_reset();
    repeat (16) ivals.push_back(int'($urandom_range(60, 140)));
    run_wave(1'b1);
    check_model("random_b", 1'b1, TO_B);
  endtask

  task automatic test_timeout();
    int r0, r2;
    do_reset();
    rise(1'b1);
    r0 = rises[0];
    wait_neg(r0 + 103);
    checks++;
    if (timeout_b !== 1'b0) begin
      failures++; $display("FAIL timeout_early: got %0b expected 0", timeout_b);
    end
    wait_neg(r0 + 104);
    checks++;
    if (timeout_b !== 1'b1 || period_b !== 32'd0) begin
      failures++;
      $display("FAIL timeout_set: got timeout %0b period %0d expected 1 and 0", timeout_b, period_b);
    end
    repeat (20) @(posedge clk);
    rise(1'b1);
    r2 = rises[1];
    wait_neg(r2 + 3);
    checks++;
    if (timeout_b !== 1'b1) begin
      failures++; $display("FAIL timeout_hold: got %0b expected 1", timeout_b);
    end
    wait_neg(r2 + 4);
    checks++;
    if (timeout_b !== 1'b0) begin
      failures++; $display("FAIL timeout_clear: got %0b expected 0", timeout_b);
    end
    gap(10);
    rise(1'b1);
    repeat (8) @(posedge clk);
    check_model("timeout_restart", 1'b1, TO_B);
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    ivals.push_back(100);
    run_wave(1'b1);
    check_model("boundary_100", 1'b1, TO_B);
    checks++;
    if (saw_to_b !== 1'b0) begin
      failures++; $display("FAIL boundary_100_timeout: got 1 expected 0");
    end
    do_reset();
    ivals.push_back(101);
    ivals.push_back(5);
    run_wave(1'b1);
    check_model("boundary_101", 1'b1, TO_B);
    checks++;
    if (saw_to_b !== 1'b1) begin
      failures++; $display("FAIL boundary_101_timeout: got 0 expected 1");
    end
  endtask

  task automatic test_reset_mid();
    int exp_n;
`ifdef PERIOD_METER_AVG_EN
    exp_n = 0;
`else
    exp_n = 3;
`endif
    do_reset();
    rise(1'b0);
    repeat (5) begin gap(6); rise(1'b0); end
    repeat (3) @(posedge clk);
    checks++;
    if (period_a !== 32'd120) begin
      failures++; $display("FAIL reset_mid_pre: got %0d expected 120", period_a);
    end
    @(posedge clk); #5 rst_n = 1'b0;
    #1;
    checks++;
    if (period_a !== 32'd0 || valid_a !== 1'b0 || timeout_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got %0d/%0b/%0b expected 0/0/0", period_a, valid_a, timeout_a);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rises.delete(); ivals.delete(); oc_a.delete(); op_a.delete();
    repeat (3) ivals.push_back(6);
    run_wave(1'b0);
    check_model("reset_mid_after", 1'b0, TO_A);
    checks++;
    if (oc_a.size() != exp_n) begin
      failures++; $display("FAIL reset_mid_count: got %0d expected %0d", oc_a.size(), exp_n);
    end
  endtask

  task automatic test_avg_pattern();
    do_reset();
    ivals = '{5, 6, 7, 6};
    run_wave(1'b0);
    check_model("avg_pattern", 1'b0, TO_A);
    checks++;
`ifdef PERIOD_METER_AVG_EN
    if (op_a.size() != 1 || op_a[0] != 64'd120) begin
      failures++;
      $display("FAIL avg_pattern_values: got %0d valids period %0d expected 1 valid period 120",
               op_a.size(), period_a);
    end
`else
    if (op_a.size() != 4 || op_a[0] != 64'd100 || op_a[1] != 64'd120 ||
        op_a[2] != 64'd140 || op_a[3] != 64'd120) begin
      failures++;
      $display("FAIL avg_pattern_values: got %0d valids last period %0d expected 100,120,140,120",
               op_a.size(), period_a);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_pulse_gen();
    test_avg_pattern();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_back_to_back();
    test_square_1khz();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
